// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the external SRAM data-memory path
//
// Purpose : FSM state encoding and default geometry/timing constants used by
//           sram_controller and sram_phase_timer.
// Ports   : none (package)

package mips_mem_pkg;

   // Byte address of data word 0 as seen by the MEM stage.
   localparam int unsigned DATA_BASE_ADDR  = 1024;

   // External SRAM data bus width.
   localparam int unsigned SRAM_DQ_W       = 16;

   // Default SRAM geometry and per-half-word wait cycles.
   localparam int unsigned DEF_SRAM_AW     = 18;
   localparam int unsigned DEF_WAIT_CYCLES = 1;

   // Phase counter width; WAIT_CYCLES is limited to 1..15 so 4 bits suffice.
   localparam int unsigned PHASE_CNT_W     = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } sram_state_t;

endpackage

// File: rtl/sram_phase_timer.sv
// rtl/sram_phase_timer.sv - per-phase cycle counter for one half-word SRAM access
//
// Purpose : Counts the WAIT_CYCLES+1 cycles of a LO or HI phase. The counter
//           runs while run=1 and wraps to 0 after the last cycle so the next
//           phase starts cleanly.
// Ports   : clk               in  clock, rising edge
//           rst_n             in  asynchronous active-low reset
//           run               in  1 while the controller is in a LO/HI phase
//           last_cycle        out current cycle is the final one of the phase
//           first_cycles_next out next cycle falls in the first WAIT_CYCLES of a phase

module sram_phase_timer
   import mips_mem_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic last_cycle,
   output logic first_cycles_next
);

   localparam logic [PHASE_CNT_W-1:0] LAST_CNT = PHASE_CNT_W'(WAIT_CYCLES);

   logic [PHASE_CNT_W-1:0] cnt_q;
   logic [PHASE_CNT_W-1:0] cnt_d;

   assign last_cycle = (cnt_q == LAST_CNT);

   always_comb begin
      cnt_d = '0;
      if (run && !last_cycle) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Looks at the next count so the registered write strobe lines up with
   // the cycle it belongs to.
   assign first_cycles_next = (cnt_d < LAST_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit MEM-stage load/store over a 16-bit asynchronous SRAM
//
// Purpose : Splits each 32-bit access into a low and a high half-word SRAM
//           access and holds ready low while the access is in flight.
// Ports   : clk          in  pipeline clock, rising edge
//           rst          in  asynchronous active-low reset
//           wr_en        in  store request
//           rd_en        in  load request
//           address      in  byte address
//           write_data   in  store value
//           read_data    out assembled load value (held until next load completes)
//           ready        out 0 = freeze pipeline
//           sram_addr    out half-word address
//           sram_dq_out  out write data to SRAM
//           sram_dq_in   in  read data from SRAM
//           sram_dq_oe   out controller drives DQ
//           sram_we_n    out write strobe, active-low

module sram_controller
   import mips_mem_pkg::*;
#(
   parameter int unsigned BASE_ADDR   = DATA_BASE_ADDR,
   parameter int unsigned SRAM_AW     = DEF_SRAM_AW,
   parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic                 rd_en,
   input  logic [31:0]          address,
   input  logic [31:0]          write_data,
   output logic [31:0]          read_data,
   output logic                 ready,
   output logic [SRAM_AW-1:0]   sram_addr,
   output logic [SRAM_DQ_W-1:0] sram_dq_out,
   input  logic [SRAM_DQ_W-1:0] sram_dq_in,
   output logic                 sram_dq_oe,
   output logic                 sram_we_n
);

   sram_state_t state_q, state_d;

   logic                 op_write_q, op_write_d;
   logic [SRAM_AW-2:0]   hw_base_q, hw_base_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [SRAM_DQ_W-1:0] held_low_q, held_low_d;
   logic [31:0]          read_data_q, read_data_d;
   logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
   logic [SRAM_DQ_W-1:0] sram_dq_out_q, sram_dq_out_d;
   logic                 sram_dq_oe_q, sram_dq_oe_d;
   logic                 sram_we_n_q, sram_we_n_d;

   logic phase_run;
   logic last_cycle;
   logic first_cycles_next;

   // Word index relative to BASE_ADDR. Wrap-around below the base and
   // truncation to the SRAM size are intentional; no error is flagged.
   function automatic logic [SRAM_AW-2:0] word_index(input logic [31:0] byte_addr);
      return (SRAM_AW-1)'((byte_addr - 32'(BASE_ADDR)) >> 2);
   endfunction

   assign phase_run = (state_q == ST_LO) || (state_q == ST_HI);

   sram_phase_timer #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_phase_timer (
      .clk               (clk),
      .rst_n             (rst),
      .run               (phase_run),
      .last_cycle        (last_cycle),
      .first_cycles_next (first_cycles_next)
   );

   always_comb begin
      state_d     = state_q;
      op_write_d  = op_write_q;
      hw_base_d   = hw_base_q;
      wdata_d     = wdata_q;
      held_low_d  = held_low_q;
      read_data_d = read_data_q;

      case (state_q)
         ST_IDLE: begin
            if (rd_en || wr_en) begin
               state_d    = ST_LO;
               op_write_d = wr_en;   // store wins when both are asserted
               hw_base_d  = word_index(address);
               wdata_d    = write_data;
            end
         end
         ST_LO: begin
            if (last_cycle) begin
               state_d = ST_HI;
               if (!op_write_q) begin
                  held_low_d = sram_dq_in;
               end
            end
         end
         ST_HI: begin
            if (last_cycle) begin
               state_d = ST_DONE;
               if (!op_write_q) begin
                  read_data_d = {sram_dq_in, held_low_q};
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // SRAM pins are registered, so they are computed from the next state and
   // next phase count; this keeps them aligned with the state they describe.
   always_comb begin
      sram_addr_d   = sram_addr_q;
      sram_dq_out_d = sram_dq_out_q;
      sram_dq_oe_d  = 1'b0;
      sram_we_n_d   = 1'b1;

      if ((state_d == ST_LO) || (state_d == ST_HI)) begin
         sram_addr_d = {hw_base_d, (state_d == ST_HI)};
         if (op_write_d) begin
            sram_dq_oe_d  = 1'b1;
            sram_dq_out_d = (state_d == ST_HI) ? wdata_d[31:16] : wdata_d[15:0];
            // Strobe released on the phase's last cycle to give data hold.
            sram_we_n_d   = !first_cycles_next;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         op_write_q    <= 1'b0;
         hw_base_q     <= '0;
         wdata_q       <= '0;
         held_low_q    <= '0;
         read_data_q   <= '0;
         sram_addr_q   <= '0;
         sram_dq_out_q <= '0;
         sram_dq_oe_q  <= 1'b0;
         sram_we_n_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         op_write_q    <= op_write_d;
         hw_base_q     <= hw_base_d;
         wdata_q       <= wdata_d;
         held_low_q    <= held_low_d;
         read_data_q   <= read_data_d;
         sram_addr_q   <= sram_addr_d;
         sram_dq_out_q <= sram_dq_out_d;
         sram_dq_oe_q  <= sram_dq_oe_d;
         sram_we_n_q   <= sram_we_n_d;
      end
   end

   // An idle request must freeze the pipeline in the same cycle it appears.
   assign ready = (state_q == ST_IDLE) ? !(rd_en || wr_en) : (state_q == ST_DONE);

   assign read_data   = read_data_q;
   assign sram_addr   = sram_addr_q;
   assign sram_dq_out = sram_dq_out_q;
   assign sram_dq_oe  = sram_dq_oe_q;
   assign sram_we_n   = sram_we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - scoreboard bench for sram_controller with an SRAM model

module tb_sram_controller;

   localparam int unsigned BASE = 1024;
   localparam int unsigned AW   = 18;
   localparam int unsigned WAIT = 1;
   localparam int unsigned LAT  = 2 * (WAIT + 1) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic          rd_en;
   logic [31:0]   address;
   logic [31:0]   write_data;
   logic [31:0]   read_data;
   logic          ready;
   logic [AW-1:0] sram_addr;
   logic [15:0]   sram_dq_out;
   logic [15:0]   sram_dq_in;
   logic          sram_dq_oe;
   logic          sram_we_n;

   sram_controller #(
      .BASE_ADDR   (BASE),
      .SRAM_AW     (AW),
      .WAIT_CYCLES (WAIT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .address     (address),
      .write_data  (write_data),
      .read_data   (read_data),
      .ready       (ready),
      .sram_addr   (sram_addr),
      .sram_dq_out (sram_dq_out),
      .sram_dq_in  (sram_dq_in),
      .sram_dq_oe  (sram_dq_oe),
      .sram_we_n   (sram_we_n)
   );

   always #5 clk = ~clk;

   // Behavioural asynchronous SRAM: owned by the monitor process.
   logic [15:0] sram_mem [0:(1<<AW)-1];
   assign sram_dq_in = sram_dq_oe ? 16'h0000 : sram_mem[sram_addr];

   typedef struct {
      bit          is_write;
      logic [31:0] hw;
      logic [31:0] data;
      logic [31:0] old_rd;
      bit          gap;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] ref_mem [int];
   logic [31:0] model_rd = 32'h0;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Word-level reference: offset from base, in words, modulo the SRAM size.
   function automatic int unsigned ref_word(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return int'((off / 4) % (32'd1 << (AW - 1)));
   endfunction

   task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit gap);
      exp_t        e;
      int unsigned w;
      w          = ref_word(a);
      e.is_write = wr;
      e.hw       = 2 * w;
      e.gap      = gap;
      e.old_rd   = model_rd;
      if (wr) begin
         ref_mem[w] = d;
         e.data     = d;
      end else begin
         e.data   = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
         model_rd = e.data;
      end
      exp_q.push_back(e);
      rd_en      = rd;
      wr_en      = wr;
      address    = a;
      write_data = d;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready) break;
      end
      chk("ready_timeout", 32'(ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle(input int n);
      rd_en = 1'b0;
      wr_en = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: tracks each access and compares against the scoreboard at ready.
   initial begin : monitor
      int   cyc_now;
      int   cyc;
      int   we_cnt;
      int   last_done;
      bit   busy;
      exp_t e;
      cyc_now = 0; cyc = 0; we_cnt = 0; last_done = -100; busy = 0;
      for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0000;
      forever begin
         @(negedge clk);
         cyc_now++;
         if (!rst) begin
            busy = 0;
            continue;
         end
         if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] = sram_dq_out;
         if (rd_en || wr_en) begin
            if (!busy) begin
               busy = 1; cyc = 0; we_cnt = 0;
            end else begin
               cyc++;
            end
            if (!sram_we_n) we_cnt++;
            if (ready) begin
               busy = 0;
               chk("sb_has_entry", 32'(exp_q.size()), 32'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("latency", 32'(cyc), 32'(LAT));
                  if (e.is_write) begin
                     chk("sram_lo", 32'(sram_mem[e.hw[AW-1:0]]), 32'(e.data[15:0]));
                     chk("sram_hi", 32'(sram_mem[e.hw[AW-1:0] + 1'b1]), 32'(e.data[31:16]));
                     chk("wr_keeps_read_data", read_data, e.old_rd);
                     chk("we_low_cycles", 32'(we_cnt), 32'(2 * WAIT));
                  end else begin
                     chk("read_data", read_data, e.data);
                     chk("rd_we_low_cycles", 32'(we_cnt), 32'd0);
                  end
                  if (e.gap) chk("ready_gap", 32'(cyc_now - last_done), 32'(LAT + 1));
               end
               last_done = cyc_now;
            end
         end
      end
   end

   initial begin : driver
      logic [31:0] a;
      int          k;
      int          idle_n;
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_ready", 32'(ready), 32'd1);
         chk("idle_we_n", 32'(sram_we_n), 32'd1);
         chk("idle_oe", 32'(sram_dq_oe), 32'd0);
      end
      chk("reset_read_data", read_data, 32'h0);
      @(posedge clk); #1;

      issue(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0);
      go_idle(1);
      issue(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
      go_idle(2);
      issue(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
      issue(1'b1, 1'b0, 32'd1032, 32'h0, 1'b1);
      go_idle(1);
      issue(1'b1, 1'b1, 32'd1036, 32'h12345678, 1'b0);
      go_idle(1);
      issue(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);
      go_idle(1);

      idle_n = 1;
      for (int t = 0; t < 60; t++) begin
         k = int'($urandom_range(0, 9));
         if (k == 0) a = BASE - 4 * $urandom_range(1, 4) + $urandom_range(0, 3);
         else        a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
         k = int'($urandom_range(0, 3));
         issue(k == 0 || k == 1, k != 1, a, $urandom, idle_n == 0 && t > 0);
         idle_n = int'($urandom_range(0, 2));
         if (idle_n > 0) go_idle(idle_n);
      end
      go_idle(2);

      // Reset in the HI phase of a store, away from any clock edge.
      wr_en = 1'b1; address = BASE + 400; write_data = 32'hA5A5_5A5A;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_we_n", 32'(sram_we_n), 32'd1);
      chk("abort_oe", 32'(sram_dq_oe), 32'd0);
      wr_en = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("post_reset_ready", 32'(ready), 32'd1);
      @(posedge clk); #1;
      issue(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
      go_idle(3);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Replaces the on-chip data-memory array behind the MEM stage with an external 16-bit asynchronous SRAM.
- Accepts one 32-bit load/store per request from the MEM stage and splits it into two 16-bit SRAM accesses (low half, then high half).
- Drops ready for the duration of each access; the top level ORs ~ready into the pipeline freeze so every stage holds.

Parameters:
- BASE_ADDR, 1024: byte address of data word 0; subtracted before mapping to SRAM.
- SRAM_AW, 18: SRAM address width in 16-bit half-words.
- WAIT_CYCLES, 1: extra cycles per half-word access; each phase lasts WAIT_CYCLES+1 cycles (legal range 1..15).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- wr_en  in  1  store request from MEM stage (MEM_W_EN).
- rd_en  in  1  load request from MEM stage (MEM_R_EN).
- address  in  32  byte address (ALU result).
- write_data  in  32  store value (ST_val).
- read_data  out  32  assembled load value.
- ready  out  1  1 = no access pending or access completing this cycle; 0 = freeze pipeline.
- sram_addr  out  SRAM_AW  half-word address to SRAM.
- sram_dq_out  out  16  write data to SRAM.
- sram_dq_in  in  16  read data from SRAM.
- sram_dq_oe  out  1  1 = controller drives DQ.
- sram_we_n  out  1  SRAM write strobe, active-low.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0.
  - sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, read_data=0.
- Ready logic: ready = ~(rd_en|wr_en) when state=IDLE; 0 in LO/HI; 1 in DONE. Combinational from state and requests.
- Address map:
  - word = (address - BASE_ADDR) >> 2, unsigned 32-bit subtraction; bits [1:0] are ignored.
  - Low half = {word[SRAM_AW-2:0],1'b0}; high half = {word[SRAM_AW-2:0],1'b1}.
  - Addresses below BASE_ADDR wrap modulo 2^32 and are truncated; no error is flagged.
- Request latch: in IDLE with a request, latch op, address and write_data, then go to LO next cycle. Later changes to the inputs are ignored until DONE.
- Simultaneous rd_en and wr_en: the write wins; no read is performed.
- FSM (all SRAM outputs registered):
  - IDLE: on rd_en|wr_en -> LO; counter=0.
  - LO:
    - Drive the low-half address.
    - Write: sram_dq_oe=1, sram_dq_out=data[15:0], sram_we_n=0 for the first WAIT_CYCLES cycles and 1 on the last cycle of the phase (data hold).
    - Read: sram_dq_oe=0, sram_we_n=1; capture sram_dq_in into a holding register on the last cycle.
    - After WAIT_CYCLES+1 cycles -> HI; counter=0.
  - HI: same as LO using the high-half address and data[31:16]. On a read, the last cycle loads read_data = {sram_dq_in, held_low}. -> DONE.
  - DONE: ready=1 for exactly one cycle, sram_dq_oe=0, sram_we_n=1 -> IDLE.
- Latency: total 2*(WAIT_CYCLES+1)+2 cycles from request to return to IDLE. With WAIT_CYCLES=1 that is 6 cycles: request seen at cycle 0, ready=0 for cycles 0-4, ready=1 at cycle 5.
- Back-to-back requests: the IDLE cycle is always spent after DONE, so each access costs its full latency.
- read_data holds its value until the next read completes; writes leave it unchanged.
- Reset mid-operation: abort immediately; sram_we_n=1 and sram_dq_oe=0 asynchronously; no partial-write recovery.
- Counter width: 4 bits; it saturates nothing because its range is bounded by WAIT_CYCLES ≤ 15.

Decomposition:
- Package mips_mem_pkg:
  - 2-bit state enum IDLE/LO/HI/DONE.
  - DATA_BASE_ADDR=1024.
  - SRAM_DQ_W=16.
  - Default SRAM_AW and WAIT_CYCLES constants.
- One natural sub-module, sram_phase_timer: the counter plus last_cycle and first_cycles strobes, reused for both phases. Everything else stays in sram_controller.

Test Plan:
- Idle, no request for 10 cycles: ready=1 throughout; sram_we_n=1; sram_dq_oe=0; read_data=0.
- Store address=1028, write_data=0xDEADBEEF:
  - SRAM half-word 2 = 0xBEEF and half-word 3 = 0xDEAD.
  - sram_we_n low for exactly 1 cycle per phase.
  - ready=0 cycles 0-4, ready=1 at cycle 5.
- Load from 1028 after that store: read_data=0xDEADBEEF exactly at the DONE cycle; ready pattern as above.
- Two consecutive loads (1024, then 1032), each held until ready: the second ready pulse arrives 6 cycles after the first; both values are correct.
- rd_en=wr_en=1, address=1036, data=0x12345678: a write is performed; read_data is unchanged.
- rst=0 asserted in HI during a store: sram_we_n=1 and sram_dq_oe=0 immediately; after release state=IDLE and ready=1 with no request.
